// File: rtl/jump_button_conditioner_if.sv
// Button-side signal bundle between the raw KEY pin, the conditioner and the PIO/debug consumers.
// The slave modport is the conditioner itself; master is whoever drives the pin and reads the results.
interface jump_button_conditioner_if;
    logic       button_raw;
    logic       jump_out;
    logic       button_level;
    logic       press_pulse;
    logic [7:0] press_count;

    modport master (
        output button_raw,
        input  jump_out,
        input  button_level,
        input  press_pulse,
        input  press_count
    );

    modport slave (
        input  button_raw,
        output jump_out,
        output button_level,
        output press_pulse,
        output press_count
    );
endinterface

// File: rtl/jump_button_conditioner.sv
// Synchronises, debounces and pulse-stretches the raw jump push-button for the PIO in_port,
// and also provides a one-cycle press pulse and a wrapping press counter for debug.
module jump_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_WIDTH       = 20,
    parameter int unsigned STRETCH_CYCLES  = 2500000,
    parameter int unsigned STRETCH_WIDTH   = 22,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    jump_button_conditioner_if.slave    bus
);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0]     CNT_MAX      = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [STRETCH_WIDTH-1:0] STRETCH_LOAD = STRETCH_WIDTH'(STRETCH_CYCLES);

    logic                     sync_q1;
    logic                     sync_q2;
    logic                     samp;
    state_t                   state;
    state_t                   next_state;
    logic [CNT_WIDTH-1:0]     cnt;
    logic [CNT_WIDTH-1:0]     next_cnt;
    logic [STRETCH_WIDTH-1:0] stretch;
    logic [STRETCH_WIDTH-1:0] next_stretch;
    logic                     press_edge;
    logic [7:0]               press_count;

    // Sync flops reset to the idle pin level so reset itself never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= ACTIVE_LOW;
            sync_q2 <= ACTIVE_LOW;
        end else begin
            sync_q1 <= bus.button_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign samp = sync_q2 ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Any sample agreeing with the current level clears the run, so only an unbroken run toggles.
    always_comb begin
        next_state = state;
        next_cnt   = '0;
        if (samp != (state == PRESSED)) begin
            if (cnt == CNT_MAX) begin
                next_state = (state == PRESSED) ? RELEASED : PRESSED;
            end else begin
                next_cnt = cnt + 1'b1;
            end
        end
    end

    assign press_edge = (state == RELEASED) && (next_state == PRESSED);

    always_comb begin
        next_stretch = stretch;
        if (press_edge) begin
            next_stretch = STRETCH_LOAD;
        end else if (stretch != '0) begin
            next_stretch = stretch - 1'b1;
        end
    end

    // jump_out looks at next-state values so it rises with button_level, not a cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            stretch         <= '0;
            bus.jump_out    <= 1'b0;
            bus.press_pulse <= 1'b0;
            press_count     <= '0;
        end else begin
            stretch         <= next_stretch;
            bus.jump_out    <= (next_state == PRESSED) || (next_stretch != '0);
            bus.press_pulse <= press_edge;
            if (press_edge) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

    assign bus.button_level = (state == PRESSED);
    assign bus.press_count  = press_count;

endmodule

// File: tb/tb_jump_button_conditioner.sv
// Self-checking bench: a hand-derived vector table, directed corner sequences, and randomized
// pin activity compared each cycle against a run-length reference model of the button.
module tb_jump_button_conditioner;

    localparam int DEB   = 4;
    localparam int STR   = 8;
    localparam int NEVER = 1000;

    logic clk;
    logic reset;

    jump_button_conditioner_if bus ();

    jump_button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_WIDTH       (4),
        .STRETCH_CYCLES  (STR),
        .STRETCH_WIDTH   (4),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: raw pin seen two edges late, level flips after DEB consecutive disagreeing samples.
    bit pipe[$];
    bit streak[$];
    bit m_level;
    bit m_pulse;
    bit m_jump;
    int m_count;
    int since_press;

    typedef struct {
        bit rst;
        bit raw;
        bit jump;
        bit level;
        bit pulse;
        int count;
    } vec_t;

    vec_t tbl[$];

    task automatic model_step(input bit r, input bit b);
        bit s;
        if (r) begin
            pipe.delete();
            pipe.push_back(1'b1);
            pipe.push_back(1'b1);
            streak.delete();
            m_level     = 1'b0;
            m_pulse     = 1'b0;
            m_count     = 0;
            since_press = NEVER;
        end else begin
            s = ~pipe.pop_front();
            pipe.push_back(b);
            m_pulse = 1'b0;
            if (s != m_level) streak.push_back(s);
            else streak.delete();
            if (since_press < NEVER) since_press++;
            if (streak.size() == DEB) begin
                m_level = ~m_level;
                streak.delete();
                if (m_level) begin
                    m_pulse     = 1'b1;
                    m_count     = (m_count + 1) % 256;
                    since_press = 0;
                end
            end
        end
        m_jump = m_level || (since_press < STR);
    endtask

    task automatic applyStimulus(input bit r, input bit b);
        reset          = r;
        bus.button_raw = b;
        @(posedge clk);
        model_step(r, b);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_model();
        checkOutput("jump_out", int'(bus.jump_out), int'(m_jump));
        checkOutput("button_level", int'(bus.button_level), int'(m_level));
        checkOutput("press_pulse", int'(bus.press_pulse), int'(m_pulse));
        checkOutput("press_count", int'(bus.press_count), m_count);
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, b);
            check_model();
        end
    endtask

    task automatic add_row(input bit r, input bit b, input bit j, input bit l, input bit p, input int c);
        vec_t v;
        v.rst = r; v.raw = b; v.jump = j; v.level = l; v.pulse = p; v.count = c;
        tbl.push_back(v);
    endtask

    initial begin
        int drops;
        int npulse;
        int start_count;
        int len;
        bit lvl;

        reset          = 1'b1;
        bus.button_raw = 1'b0;
        pipe.push_back(1'b1);
        pipe.push_back(1'b1);
        m_level = 0; m_pulse = 0; m_jump = 0; m_count = 0; since_press = NEVER;

        // Reset, clean press (raw low at row 5, accepted at row 10), stretched release, 1-cycle glitch.
        for (int i = 0; i < 3; i++) add_row(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) add_row(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add_row(0, 0, 0, 0, 0, 0);
        add_row(0, 0, 1, 1, 1, 1);
        add_row(0, 0, 1, 1, 0, 1);
        for (int i = 0; i < 5; i++) add_row(0, 1, 1, 1, 0, 1);
        add_row(0, 1, 1, 0, 0, 1);
        add_row(0, 1, 0, 0, 0, 1);
        add_row(0, 1, 0, 0, 0, 1);
        add_row(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) add_row(0, 1, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].rst, tbl[i].raw);
            checkOutput($sformatf("tbl%0d_jump", i), int'(bus.jump_out), int'(tbl[i].jump));
            checkOutput($sformatf("tbl%0d_level", i), int'(bus.button_level), int'(tbl[i].level));
            checkOutput($sformatf("tbl%0d_pulse", i), int'(bus.press_pulse), int'(tbl[i].pulse));
            checkOutput($sformatf("tbl%0d_count", i), int'(bus.press_count), tbl[i].count);
        end

        // Glitches of 2 and 3 low cycles are rejected.
        hold(1, 5); hold(0, 2); hold(1, 5); hold(0, 3); hold(1, 5);
        checkOutput("glitch_count", int'(bus.press_count), 1);

        // 3-low / 1-high / 4-low: only the final unbroken run counts.
        hold(0, 3); hold(1, 1); hold(0, 4); hold(0, 1);
        checkOutput("late_level_before", int'(bus.button_level), 0);
        hold(0, 1);
        checkOutput("late_accept_level", int'(bus.button_level), 1);
        checkOutput("late_accept_pulse", int'(bus.press_pulse), 1);
        checkOutput("late_count", int'(bus.press_count), 2);
        hold(0, 5);

        // Stretch: short press, jump_out outlives button_level.
        hold(1, 12);
        hold(0, 6);
        checkOutput("stretch_press_pulse", int'(bus.press_pulse), 1);
        hold(0, 1); hold(1, 5);
        applyStimulus(1'b0, 1'b1);
        check_model();
        checkOutput("stretch_level_fell", int'(bus.button_level), 0);
        checkOutput("stretch_jump_held", int'(bus.jump_out), 1);
        applyStimulus(1'b0, 1'b1);
        check_model();
        checkOutput("stretch_jump_fell", int'(bus.jump_out), 0);

        // Retrigger: second acceptance lands exactly as the first stretch runs out.
        hold(1, 12);
        drops = 0; npulse = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, (i >= 4 && i < 8) ? 1'b1 : 1'b0);
            check_model();
            if (i >= 5 && !bus.jump_out) drops++;
            if (bus.press_pulse) npulse++;
        end
        checkOutput("retrigger_drops", drops, 0);
        checkOutput("retrigger_pulses", npulse, 2);

        // 256 accepted presses bring the counter back around.
        hold(1, 8);
        start_count = m_count;
        for (int i = 0; i < 256; i++) begin
            hold(0, 6);
            hold(1, 6);
        end
        checkOutput("wrap_count", int'(bus.press_count), start_count);

        // Reset mid-stretch, then re-acceptance of the still-held button.
        hold(0, 6);
        hold(0, 3);
        applyStimulus(1'b1, 1'b0);
        check_model();
        checkOutput("rst_mid_jump", int'(bus.jump_out), 0);
        checkOutput("rst_mid_count", int'(bus.press_count), 0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        npulse = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0);
            check_model();
            if (bus.press_pulse) npulse++;
        end
        checkOutput("post_reset_early_pulses", npulse, 0);
        applyStimulus(1'b0, 1'b0);
        check_model();
        checkOutput("post_reset_accept", int'(bus.press_pulse), 1);

        // Randomized pin activity with occasional reset bursts.
        lvl = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) begin
                    applyStimulus(1'b1, lvl);
                    check_model();
                end
            end
            lvl = ~lvl;
            hold(lvl, $urandom_range(1, 9));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
